snake_grid_engine: RTL and testbench

- Single-clock snake game core on a 40x30 cell grid, 16x16 px cells, 640x480 visible.
- Generates its own move tick from the VGA scan position and moves the snake one cell per tick.
- Handles apple eating, growth, and wall/self collision.
- Returns, one cycle after each pixel coordinate, the entity code at that pixel for the VGA colour mux.

---
 rtl/snake_grid_engine_if.sv | 32 +++
 rtl/snake_grid_engine.sv | 207 ++++++++++++++++++++
 tb/tb_snake_grid_engine.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/snake_grid_engine_if.sv
// Purpose: groups the snake core's steering, scan-position, game-state and
//          result signals into one bundle.
// Ports (signals):
//   direction  [1:0]  requested heading (00 up, 01 right, 10 down, 11 left)
//   x_in       [9:0]  current VGA pixel column
//   y_in       [9:0]  current VGA pixel row
//   game_state [2:0]  0 START, 1 INGAME, other values freeze the game
//   entity     [1:0]  entity at the previous cycle's pixel
//   tail_count [7:0]  number of body segments (score)
//   game_over         sticky collision flag
//   game_won          sticky win flag
// Modports: master drives the inputs of the core, slave is the core itself.
interface snake_grid_engine_if;
  logic [1:0] direction;
  logic [9:0] x_in;
  logic [9:0] y_in;
  logic [2:0] game_state;
  logic [1:0] entity;
  logic [7:0] tail_count;
  logic       game_over;
  logic       game_won;

  modport master (
    output direction, x_in, y_in, game_state,
    input  entity, tail_count, game_over, game_won
  );

  modport slave (
    input  direction, x_in, y_in, game_state,
    output entity, tail_count, game_over, game_won
  );
endinterface

// File: rtl/snake_grid_engine.sv
// Purpose: snake game core on a GRID_W x GRID_H cell grid. Derives a move
//          tick from the VGA scan position, moves the snake one cell per
//          tick, handles apple eating, growth, wall/self collision, and
//          reports the entity under the current pixel one cycle later.
// Ports:
//   vga_clk  single pixel/system clock, rising edge
//   reset_p  asynchronous active-high reset
//   bus      snake_grid_engine_if.slave (direction, x_in, y_in, game_state
//            in; entity, tail_count, game_over, game_won out, registered)
module snake_grid_engine #(
  parameter int unsigned CELL_BITS     = 4,
  parameter int unsigned GRID_W        = 40,
  parameter int unsigned GRID_H        = 30,
  parameter int unsigned MAX_TAIL      = 16,
  parameter int unsigned UPDATE_FRAMES = 8,
  parameter logic [15:0] APPLE_SEED    = 16'hACE1
) (
  input  logic                vga_clk,
  input  logic                reset_p,
  snake_grid_engine_if.slave  bus
);

  localparam int unsigned XW    = $clog2(GRID_W);
  localparam int unsigned YW    = $clog2(GRID_H);
  localparam int unsigned TW    = 8;
  localparam int unsigned PIX_W = GRID_W << CELL_BITS;
  localparam int unsigned PIX_H = GRID_H << CELL_BITS;

  localparam logic [2:0] GS_START  = 3'd0;
  localparam logic [2:0] GS_INGAME = 3'd1;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_RIGHT = 2'b01,
    DIR_DOWN  = 2'b10,
    DIR_LEFT  = 2'b11
  } dir_e;

  logic [XW-1:0] head_x_q, head_x_d;
  logic [YW-1:0] head_y_q, head_y_d;
  dir_e          heading_q, heading_d;
  dir_e          pending_q, pending_d;
  logic [XW-1:0] seg_x_q [MAX_TAIL];
  logic [XW-1:0] seg_x_d [MAX_TAIL];
  logic [YW-1:0] seg_y_q [MAX_TAIL];
  logic [YW-1:0] seg_y_d [MAX_TAIL];
  logic [TW-1:0] tail_q, tail_d;
  logic [XW-1:0] apple_x_q, apple_x_d;
  logic [YW-1:0] apple_y_q, apple_y_d;
  logic          over_q, over_d;
  logic          won_q, won_d;
  logic [1:0]    entity_q, entity_d;
  logic [2:0]    frame_cnt_q, frame_cnt_d;
  logic          was_upd_q, was_upd_d;
  logic [15:0]   lfsr_q, lfsr_d;

  logic          frame_end, frame_new, tick, act;
  logic          wall, self_hit;
  logic [XW-1:0] next_x, reloc_x, cell_x;
  logic [YW-1:0] next_y, reloc_y, cell_y;
  logic [5:0]    rnd_x;
  logic [4:0]    rnd_y;
  logic          in_range, body_hit;

  // Next-state logic: tick generation, heading, movement, apple, entity.
  always_comb begin
    head_x_d    = head_x_q;
    head_y_d    = head_y_q;
    heading_d   = heading_q;
    seg_x_d     = seg_x_q;
    seg_y_d     = seg_y_q;
    tail_d      = tail_q;
    apple_x_d   = apple_x_q;
    apple_y_d   = apple_y_q;
    over_d      = over_q;
    won_d       = won_q;
    frame_cnt_d = frame_cnt_q;
    wall        = 1'b0;
    self_hit    = 1'b0;
    body_hit    = 1'b0;
    next_x      = head_x_q;
    next_y      = head_y_q;

    // Fibonacci LFSR, taps 16,14,13,11; free-running.
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    // Count only the first cycle of a held frame-end position.
    frame_end = (bus.x_in == 10'(PIX_W - 1)) && (bus.y_in == 10'(PIX_H - 1));
    was_upd_d = frame_end;
    frame_new = frame_end && !was_upd_q;
    tick      = frame_new && (frame_cnt_q == 3'(UPDATE_FRAMES - 1));
    if (frame_new) frame_cnt_d = tick ? 3'd0 : frame_cnt_q + 3'd1;

    // A direction that reverses the current heading is ignored.
    pending_d = (bus.direction == (heading_q ^ 2'b10)) ? pending_q : dir_e'(bus.direction);

    // Candidate head one cell along the pending heading; walls flagged.
    unique case (pending_q)
      DIR_UP:    if (head_y_q == '0) wall = 1'b1; else next_y = head_y_q - YW'(1);
      DIR_DOWN:  if (head_y_q == YW'(GRID_H - 1)) wall = 1'b1; else next_y = head_y_q + YW'(1);
      DIR_LEFT:  if (head_x_q == '0) wall = 1'b1; else next_x = head_x_q - XW'(1);
      DIR_RIGHT: if (head_x_q == XW'(GRID_W - 1)) wall = 1'b1; else next_x = head_x_q + XW'(1);
    endcase

    for (int i = 0; i < MAX_TAIL; i++) begin
      if ((TW'(i) < tail_q) && (seg_x_q[i] == next_x) && (seg_y_q[i] == next_y)) self_hit = 1'b1;
    end

    // Fold LFSR slices into the grid by a single conditional subtraction.
    rnd_x   = lfsr_q[5:0];
    rnd_y   = lfsr_q[12:8];
    reloc_x = XW'((rnd_x >= 6'(GRID_W)) ? rnd_x - 6'(GRID_W) : rnd_x);
    reloc_y = YW'((rnd_y >= 5'(GRID_H)) ? rnd_y - 5'(GRID_H) : rnd_y);

    act = tick && (bus.game_state == GS_INGAME) && !over_q && !won_q;

    if (bus.game_state == GS_START) begin
      head_x_d    = XW'(20);
      head_y_d    = YW'(15);
      heading_d   = DIR_RIGHT;
      pending_d   = DIR_RIGHT;
      tail_d      = '0;
      apple_x_d   = XW'(30);
      apple_y_d   = YW'(15);
      over_d      = 1'b0;
      won_d       = 1'b0;
      frame_cnt_d = '0;
    end else if (act) begin
      heading_d = pending_q;
      if (wall || self_hit) begin
        over_d = 1'b1;
      end else begin
        seg_x_d[0] = head_x_q;
        seg_y_d[0] = head_y_q;
        for (int i = 1; i < MAX_TAIL; i++) begin
          seg_x_d[i] = seg_x_q[i-1];
          seg_y_d[i] = seg_y_q[i-1];
        end
        head_x_d = next_x;
        head_y_d = next_y;
        if ((next_x == apple_x_q) && (next_y == apple_y_q)) begin
          tail_d    = tail_q + TW'(1);
          apple_x_d = reloc_x;
          apple_y_d = reloc_y;
          if ((tail_q + TW'(1)) == TW'(MAX_TAIL)) won_d = 1'b1;
        end
      end
    end

    // Entity lookup for the current pixel: head > body > apple > empty.
    in_range = (bus.x_in < 10'(PIX_W)) && (bus.y_in < 10'(PIX_H));
    cell_x   = XW'(bus.x_in >> CELL_BITS);
    cell_y   = YW'(bus.y_in >> CELL_BITS);
    for (int i = 0; i < MAX_TAIL; i++) begin
      if ((TW'(i) < tail_q) && (seg_x_q[i] == cell_x) && (seg_y_q[i] == cell_y)) body_hit = 1'b1;
    end
    entity_d = 2'b00;
    if (bus.game_state != GS_START && in_range) begin
      if ((cell_x == head_x_q) && (cell_y == head_y_q)) entity_d = 2'b01;
      else if (body_hit)                                 entity_d = 2'b10;
      else if ((cell_x == apple_x_q) && (cell_y == apple_y_q)) entity_d = 2'b11;
    end
  end

  // State registers.
  always_ff @(posedge vga_clk or posedge reset_p) begin
    if (reset_p) begin
      head_x_q    <= XW'(20);
      head_y_q    <= YW'(15);
      heading_q   <= DIR_RIGHT;
      pending_q   <= DIR_RIGHT;
      seg_x_q     <= '{default: '0};
      seg_y_q     <= '{default: '0};
      tail_q      <= '0;
      apple_x_q   <= XW'(30);
      apple_y_q   <= YW'(15);
      over_q      <= 1'b0;
      won_q       <= 1'b0;
      entity_q    <= 2'b00;
      frame_cnt_q <= '0;
      was_upd_q   <= 1'b0;
      lfsr_q      <= APPLE_SEED;
    end else begin
      head_x_q    <= head_x_d;
      head_y_q    <= head_y_d;
      heading_q   <= heading_d;
      pending_q   <= pending_d;
      seg_x_q     <= seg_x_d;
      seg_y_q     <= seg_y_d;
      tail_q      <= tail_d;
      apple_x_q   <= apple_x_d;
      apple_y_q   <= apple_y_d;
      over_q      <= over_d;
      won_q       <= won_d;
      entity_q    <= entity_d;
      frame_cnt_q <= frame_cnt_d;
      was_upd_q   <= was_upd_d;
      lfsr_q      <= lfsr_d;
    end
  end

  assign bus.entity     = entity_q;
  assign bus.tail_count = tail_q;
  assign bus.game_over  = over_q;
  assign bus.game_won   = won_q;

endmodule

// File: tb/tb_snake_grid_engine.sv
// Purpose: self-checking bench for snake_grid_engine. Two instances share
//          one stimulus stream: dut0 with default parameters and dut1 with
//          MAX_TAIL=2. Outputs are compared each cycle with a cell-level
//          game model, plus directed checks at the key game events.
module tb_snake_grid_engine;
  localparam int UF = 8;
  localparam logic [15:0] SEED = 16'hACE1;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] dir;
  logic [9:0] px, py;
  logic [2:0] gs;
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  snake_grid_engine_if bus0 ();
  snake_grid_engine_if bus1 ();

  assign bus0.direction  = dir;
  assign bus0.x_in       = px;
  assign bus0.y_in       = py;
  assign bus0.game_state = gs;
  assign bus1.direction  = dir;
  assign bus1.x_in       = px;
  assign bus1.y_in       = py;
  assign bus1.game_state = gs;

  snake_grid_engine dut0 (.vga_clk(clk), .reset_p(rst), .bus(bus0));
  snake_grid_engine #(.MAX_TAIL(2)) dut1 (.vga_clk(clk), .reset_p(rst), .bus(bus1));

  // Game model, one copy per instance; snake cells in grid coordinates.
  int mhx[2], mhy[2], mhd[2], mpend[2], mtail[2], mapx[2], mapy[2], mcnt[2], ment[2];
  int msx[2][16], msy[2][16];
  bit mover[2], mwon[2], mwu[2];
  int mmax[2] = '{16, 2};
  logic [15:0] mlfsr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_start(input int k);
    mhx[k] = 20; mhy[k] = 15; mhd[k] = 1; mpend[k] = 1; mtail[k] = 0;
    mapx[k] = 30; mapy[k] = 15; mover[k] = 0; mwon[k] = 0; mcnt[k] = 0;
  endtask

  function automatic int ent_of(input int k, input int x, input int y);
    int cx = x / 16;
    int cy = y / 16;
    if (x >= 640 || y >= 480) return 0;
    if (cx == mhx[k] && cy == mhy[k]) return 1;
    for (int i = 0; i < mtail[k]; i++) if (cx == msx[k][i] && cy == msy[k][i]) return 2;
    if (cx == mapx[k] && cy == mapy[k]) return 3;
    return 0;
  endfunction

  task automatic advance(input int k);
    int nx, ny;
    bit hit;
    mhd[k] = mpend[k];
    nx = mhx[k] + ((mhd[k] == 1) ? 1 : (mhd[k] == 3) ? -1 : 0);
    ny = mhy[k] + ((mhd[k] == 2) ? 1 : (mhd[k] == 0) ? -1 : 0);
    hit = (nx < 0 || nx >= 40 || ny < 0 || ny >= 30);
    for (int i = 0; i < mtail[k]; i++) if (nx == msx[k][i] && ny == msy[k][i]) hit = 1;
    if (hit) begin
      mover[k] = 1;
      return;
    end
    for (int i = 15; i > 0; i--) begin
      msx[k][i] = msx[k][i-1];
      msy[k][i] = msy[k][i-1];
    end
    msx[k][0] = mhx[k]; msy[k][0] = mhy[k];
    mhx[k] = nx; mhy[k] = ny;
    if (nx == mapx[k] && ny == mapy[k]) begin
      mtail[k]++;
      mapx[k] = int'(mlfsr) % 64;
      if (mapx[k] >= 40) mapx[k] -= 40;
      mapy[k] = (int'(mlfsr) / 256) % 32;
      if (mapy[k] >= 30) mapy[k] -= 30;
      if (mtail[k] == mmax[k]) mwon[k] = 1;
    end
  endtask

  // Applies one clock edge worth of game rules to the model.
  task automatic model_edge();
    bit fe, tk;
    int np;
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        model_start(k);
        mwu[k] = 0; ment[k] = 0;
      end
      mlfsr = SEED;
      return;
    end
    for (int k = 0; k < 2; k++) begin
      ment[k] = (gs == 3'd0) ? 0 : ent_of(k, int'(px), int'(py));
      fe = (px == 10'd639 && py == 10'd479) && !mwu[k];
      mwu[k] = (px == 10'd639 && py == 10'd479);
      if (gs == 3'd0) begin
        model_start(k);
      end else begin
        tk = fe && (mcnt[k] == UF - 1);
        if (fe) mcnt[k] = tk ? 0 : mcnt[k] + 1;
        np = (int'(dir) == (mhd[k] + 2) % 4) ? mpend[k] : int'(dir);
        if (tk && gs == 3'd1 && !mover[k] && !mwon[k]) advance(k);
        mpend[k] = np;
      end
    end
    mlfsr = {mlfsr[14:0], mlfsr[15] ^ mlfsr[13] ^ mlfsr[12] ^ mlfsr[10]};
  endtask

  task automatic cycle(input logic [9:0] x, input logic [9:0] y);
    px = x; py = y;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("ent0", 32'(bus0.entity), ment[0]);
    check("tail0", 32'(bus0.tail_count), mtail[0]);
    check("over0", 32'(bus0.game_over), mover[0]);
    check("won0", 32'(bus0.game_won), mwon[0]);
    check("ent1", 32'(bus1.entity), ment[1]);
    check("tail1", 32'(bus1.tail_count), mtail[1]);
    check("over1", 32'(bus1.game_over), mover[1]);
    check("won1", 32'(bus1.game_won), mwon[1]);
  endtask

  // Random pixel, biased toward head, body and apple cells.
  task automatic rand_cycle();
    int k = $urandom_range(0, 1);
    int r = $urandom_range(0, 3);
    int x, y;
    case (r)
      0: begin x = $urandom_range(0, 700); y = $urandom_range(0, 520); end
      1: begin x = mhx[k] * 16 + $urandom_range(0, 15); y = mhy[k] * 16 + $urandom_range(0, 15); end
      2: begin
        int i = (mtail[k] > 0) ? $urandom_range(0, mtail[k] - 1) : 0;
        x = msx[k][i] * 16 + $urandom_range(0, 15); y = msy[k][i] * 16 + $urandom_range(0, 15);
      end
      default: begin x = mapx[k] * 16 + $urandom_range(0, 15); y = mapy[k] * 16 + $urandom_range(0, 15); end
    endcase
    if (x == 639 && y == 479) y = 0;
    cycle(10'(x), 10'(y));
  endtask

  task automatic frame();
    repeat (3) rand_cycle();
    cycle(10'd639, 10'd479);
  endtask

  task automatic move();
    repeat (UF) frame();
  endtask

  function automatic logic [1:0] steer();
    int hx = mhx[1], hy = mhy[1], h = mhd[1], ax = mapx[1], ay = mapy[1];
    if (ax > hx && h != 3) return 2'd1;
    if (ax < hx && h != 1) return 2'd3;
    if (ay > hy && h != 0) return 2'd2;
    if (ay < hy && h != 2) return 2'd0;
    if (h == 1 || h == 3) return (hy < 29) ? 2'd2 : 2'd0;
    return (hx < 39) ? 2'd1 : 2'd3;
  endfunction

  initial begin
    int hx, hy;
    rst = 1'b1; gs = 3'd0; dir = 2'd1; px = '0; py = '0;
    repeat (20) cycle(10'd0, 10'd0);
    check("rst_entity", 32'(bus0.entity), 0);
    check("rst_tail", 32'(bus0.tail_count), 0);
    check("rst_over", 32'(bus0.game_over), 0);
    check("rst_won", 32'(bus1.game_won), 0);
    rst = 1'b0;
    repeat (2) rand_cycle();

    // First move after eight frame ends.
    gs = 3'd1; dir = 2'd1;
    move();
    cycle(10'd336, 10'd240);
    check("first_move_head", 32'(bus0.entity), 1);
    check("first_move_tail", 32'(bus0.tail_count), 0);

    // A held frame-end position counts as a single frame.
    repeat (5) cycle(10'd639, 10'd479);
    rand_cycle();
    repeat (6) frame();
    cycle(10'd336, 10'd240);
    check("hold_no_early_move", 32'(bus0.entity), 1);
    frame();
    cycle(10'd352, 10'd240);
    check("hold_then_move", 32'(bus0.entity), 1);

    // Reverse request (left while heading right) is ignored.
    dir = 2'd3;
    repeat (7) move();
    cycle(10'd464, 10'd240);
    check("head_at_29", 32'(bus0.entity), 1);
    move();
    cycle(10'd464, 10'd240);
    check("eat_body", 32'(bus0.entity), 2);
    check("eat_tail", 32'(bus0.tail_count), 1);
    cycle(10'd480, 10'd240);
    check("eat_head", 32'(bus0.entity), 1);
    cycle(10'(mapx[0] * 16 + 7), 10'(mapy[0] * 16 + 7));

    // Run into the right wall.
    dir = 2'd1;
    repeat (10) move();
    check("wall_over", 32'(bus0.game_over), 1);
    cycle(10'd624, 10'd240);
    check("wall_head_held", 32'(bus0.entity), 1);
    repeat (2) move();
    cycle(10'd624, 10'd240);
    check("frozen_head", 32'(bus0.entity), 1);
    check("frozen_over", 32'(bus0.game_over), 1);

    // START clears everything.
    gs = 3'd0;
    repeat (2) rand_cycle();
    check("start_over", 32'(bus0.game_over), 0);
    check("start_tail", 32'(bus0.tail_count), 0);
    cycle(10'd320, 10'd240);
    check("start_entity", 32'(bus0.entity), 0);

    // Steer dut1 to two apples to win with MAX_TAIL=2.
    gs = 3'd1;
    for (int n = 0; n < 200 && !mwon[1]; n++) begin
      dir = steer();
      move();
    end
    check("won_flag", 32'(bus1.game_won), 1);
    check("won_tail", 32'(bus1.tail_count), 2);
    check("won_no_over", 32'(bus1.game_over), 0);
    check("dut0_not_won", 32'(bus0.game_won), 0);
    hx = mhx[1]; hy = mhy[1];
    repeat (3) move();
    cycle(10'(hx * 16 + 3), 10'(hy * 16 + 3));
    check("won_frozen_head", 32'(bus1.entity), 1);
    check("won_frozen_tail", 32'(bus1.tail_count), 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
